// File: rtl/mod_counter.sv
// mod_counter: parametrised wrap/saturate up/down modulo counter with registered terminal-count pulse.
// Optional prescaler enabled by defining COUNTER_PRESCALER_EN.
module mod_counter #(
  parameter int WIDTH    = 26,
  parameter int MODULUS  = 0,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data,
  output logic             tc
);
  // One extra bit keeps LIMIT and the +1 exact at 2**WIDTH-1.
  localparam logic [WIDTH:0] LIMIT = (MODULUS == 0) ? {1'b0, {WIDTH{1'b1}}} : (WIDTH+1)'(MODULUS - 1);
  logic [WIDTH-1:0] data_q, data_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   cur, nxt, ld;
  logic             tick, step, at_lim;
`ifdef COUNTER_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
  always_comb begin
    tick  = pre_q == PW'(PRESCALE - 1);
    pre_d = (clr || load) ? '0 : !en ? pre_q : tick ? '0 : pre_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
`else
  assign tick = 1'b1;
`endif
  always_comb begin
    cur    = {1'b0, data_q};
    step   = en && tick;
    at_lim = up ? (cur == LIMIT) : (cur == '0);
    nxt    = up ? (at_lim ? (SATURATE ? LIMIT : '0) : cur + 1'b1)
                : (at_lim ? (SATURATE ? '0 : LIMIT) : cur - 1'b1);
    ld     = ({1'b0, load_val} > LIMIT) ? LIMIT : {1'b0, load_val};
    data_d = clr ? '0 : load ? ld[WIDTH-1:0] : step ? nxt[WIDTH-1:0] : data_q;
    tc_d   = !clr && !load && step && at_lim;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      tc_q   <= tc_d;
    end
  assign data = data_q;
  assign tc   = tc_q;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed checks of mod_counter in default, modulo-10 wrap/saturate and prescaled configs.
module tb_mod_counter;
  logic clk = 1'b0;
  logic rst, en, up, clr, load;
  logic [25:0] lv;
  logic [25:0] d_def;
  logic [3:0]  d_w, d_s, d_p;
  logic        t_def, t_w, t_s, t_p;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  mod_counter u_def (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv), .data(d_def), .tc(t_def));
  mod_counter #(.WIDTH(4), .MODULUS(10)) u_w (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv[3:0]), .data(d_w), .tc(t_w));
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_s (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv[3:0]), .data(d_s), .tc(t_s));
  mod_counter #(.WIDTH(4), .PRESCALE(3)) u_p (.clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(lv[3:0]), .data(d_p), .tc(t_p));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; lv = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_def", {6'd0, d_def}, 0);
    chk("rst_w", {31'd0, t_w}, 0);
    rst = 1'b0; en = 1'b1;
    chk("rel_def", {6'd0, d_def}, 0);
    for (int k = 1; k <= 100; k++) begin
      cyc();
      chk("up_def", {6'd0, d_def}, k);
      chk("up_def_tc", {31'd0, t_def}, 0);
      chk("wrap_w", {28'd0, d_w}, k % 10);
      chk("wrap_w_tc", {31'd0, t_w}, (k % 10 == 0) ? 1 : 0);
      chk("sat_s", {28'd0, d_s}, (k < 9) ? k : 9);
      chk("sat_s_tc", {31'd0, t_s}, (k >= 10) ? 1 : 0);
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_def", {6'd0, d_def}, 0);
    chk("clr_w_tc", {31'd0, t_w}, 0);
    up = 1'b0;
    cyc();
    chk("dn_w", {28'd0, d_w}, 9);
    chk("dn_w_tc", {31'd0, t_w}, 1);
    chk("dn_s", {28'd0, d_s}, 0);
    chk("dn_s_tc", {31'd0, t_s}, 1);
    chk("dn_def", {6'd0, d_def}, 32'h3FFFFFF);
    chk("dn_def_tc", {31'd0, t_def}, 1);
    cyc();
    chk("dn2_w", {28'd0, d_w}, 8);
    chk("dn2_w_tc", {31'd0, t_w}, 0);
    chk("dn2_s", {28'd0, d_s}, 0);
    chk("dn2_s_tc", {31'd0, t_s}, 1);
    load = 1'b1; lv = 26'd12;
    cyc();
    chk("ld_w", {28'd0, d_w}, 9);
    chk("ld_s", {28'd0, d_s}, 9);
    chk("ld_def", {6'd0, d_def}, 12);
    chk("ld_s_tc", {31'd0, t_s}, 0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clrld_w", {28'd0, d_w}, 0);
    chk("clrld_def", {6'd0, d_def}, 0);
    lv = 26'd5;
    cyc();
    load = 1'b0; en = 1'b0;
    repeat (3) cyc();
    chk("frz_w", {28'd0, d_w}, 5);
    chk("frz_def", {6'd0, d_def}, 5);
    chk("frz_w_tc", {31'd0, t_w}, 0);
    load = 1'b1; lv = 26'd9;
    cyc();
    load = 1'b0; en = 1'b1; up = 1'b1;
    cyc();
    chk("pre_rst_w", {28'd0, d_w}, 0);
    chk("pre_rst_w_tc", {31'd0, t_w}, 1);
    chk("pre_rst_s_tc", {31'd0, t_s}, 1);
    chk("pre_rst_def", {6'd0, d_def}, 10);
    #2 rst = 1'b1;
    #1;
    chk("arst_def", {6'd0, d_def}, 0);
    chk("arst_s", {28'd0, d_s}, 0);
    chk("arst_w_tc", {31'd0, t_w}, 0);
    chk("arst_s_tc", {31'd0, t_s}, 0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = 1'b1;
`ifdef COUNTER_PRESCALER_EN
    cyc(); chk("ps1", {28'd0, d_p}, 0);
    cyc(); chk("ps2", {28'd0, d_p}, 0);
    cyc(); chk("ps3", {28'd0, d_p}, 1);
    cyc(); chk("ps4", {28'd0, d_p}, 1);
    en = 1'b0;
    cyc(); cyc(); chk("ps_hold", {28'd0, d_p}, 1);
    en = 1'b1;
    cyc(); chk("ps5", {28'd0, d_p}, 1);
    cyc(); chk("ps6", {28'd0, d_p}, 2);
`else
    cyc(); chk("np1", {28'd0, d_p}, 1);
    cyc(); chk("np2", {28'd0, d_p}, 2);
    en = 1'b0;
    cyc(); cyc(); chk("np_hold", {28'd0, d_p}, 2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
